// File: rtl/sample_encoder_pkg.sv
// Shared constants for the sample encoder, its decoder and the sample-memory builder.
// Holds the state encoding, group/shift limits, word layout and address width.
package sample_encoder_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_TRY     = 2'd1,
        ST_EMIT    = 2'd2
    } enc_state_t;

    localparam int GROUP     = 4;
    localparam int MAX_SHIFT = 4;
    localparam int ADDR_W    = 14;
    localparam int WORD_W    = 20;
    localparam int FIELD_W   = 4;

    // Word layout, MSB first: {shift, d0, d1, d2, d3}
    localparam int SHIFT_LSB = 16;
    localparam int D0_LSB    = 12;
    localparam int D1_LSB    = 8;
    localparam int D2_LSB    = 4;
    localparam int D3_LSB    = 0;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [FIELD_W-1:0] shift,
        input logic [FIELD_W-1:0] d0,
        input logic [FIELD_W-1:0] d1,
        input logic [FIELD_W-1:0] d2,
        input logic [FIELD_W-1:0] d3
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[SHIFT_LSB +: FIELD_W] = shift;
        w[D0_LSB    +: FIELD_W] = d0;
        w[D1_LSB    +: FIELD_W] = d1;
        w[D2_LSB    +: FIELD_W] = d2;
        w[D3_LSB    +: FIELD_W] = d3;
        return w;
    endfunction

endpackage

// File: rtl/sample_encoder_quant.sv
// One DPCM step: quantise the prediction error at a given shift and rebuild the sample
// exactly as the decoder will. Purely combinational.
module dpcm_quant (
    input  logic signed [7:0] x,
    input  logic signed [7:0] pw,
    input  logic        [2:0] shift,
    output logic signed [3:0] qc,
    output logic              clamped,
    output logic signed [7:0] r
);

    localparam logic signed [8:0] Q_MAX = 9'sd7;
    localparam logic signed [8:0] Q_MIN = -9'sd8;
    localparam logic signed [9:0] R_MAX = 10'sd127;
    localparam logic signed [9:0] R_MIN = -10'sd128;

    logic signed [8:0] e;
    logic signed [8:0] q;
    logic signed [9:0] step;
    logic signed [9:0] sum;

    always_comb begin
        e       = $signed({x[7], x}) - $signed({pw[7], pw});
        q       = e >>> shift;
        clamped = 1'b0;
        qc      = q[3:0];
        if (q > Q_MAX) begin
            qc      = 4'sd7;
            clamped = 1'b1;
        end else if (q < Q_MIN) begin
            qc      = -4'sd8;
            clamped = 1'b1;
        end
        step = $signed({{6{qc[3]}}, qc}) <<< shift;
        sum  = $signed({{2{pw[7]}}, pw}) + step;
        // Reconstruction saturates so the decoder never wraps
        if (sum > R_MAX) begin
            r = 8'sd127;
        end else if (sum < R_MIN) begin
            r = -8'sd128;
        end else begin
            r = sum[7:0];
        end
    end

endmodule

// File: rtl/sample_encoder.sv
// Block-DPCM encoder: collects groups of 4 samples, searches the smallest shift that
// avoids clamping, and emits one packed 20-bit word per group.
module sample_encoder
    import sample_encoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic signed [7:0]   sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                flush,
    output logic [WORD_W-1:0]   word,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [ADDR_W-1:0]   word_addr
);

    enc_state_t state_q, state_d;

    logic        [2:0]        cnt_q, cnt_d;
    logic signed [7:0]        x_q [GROUP];
    logic signed [7:0]        x_d [GROUP];
    logic signed [3:0]        qc_q [GROUP];
    logic signed [3:0]        qc_d [GROUP];
    logic signed [7:0]        p_q, p_d;
    logic signed [7:0]        pw_q, pw_d;
    logic signed [7:0]        pred_q, pred_d;
    logic        [2:0]        shift_q, shift_d;
    logic        [1:0]        idx_q, idx_d;
    logic                     fail_q, fail_d;
    logic        [WORD_W-1:0] word_q, word_d;
    logic        [ADDR_W-1:0] addr_q, addr_d;

    logic                     accept;
    logic        [2:0]        cnt_acc;
    logic signed [7:0]        last_smp;
    logic                     cand_fail;

    logic signed [7:0]        qx;
    logic signed [3:0]        qqc;
    logic                     qclamped;
    logic signed [7:0]        qr;

    assign qx = x_q[idx_q];

    dpcm_quant u_quant (
        .x       (qx),
        .pw      (pw_q),
        .shift   (shift_q),
        .qc      (qqc),
        .clamped (qclamped),
        .r       (qr)
    );

    assign sample_ready = (state_q == ST_COLLECT);
    assign word_valid   = (state_q == ST_EMIT);
    assign word         = word_q;
    assign word_addr    = addr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        qc_d      = qc_q;
        p_d       = p_q;
        pw_d      = pw_q;
        pred_d    = pred_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        fail_d    = fail_q;
        word_d    = word_q;
        addr_d    = addr_q;
        accept    = 1'b0;
        cnt_acc   = cnt_q;
        last_smp  = x_q[cnt_q[1:0] - 2'd1];
        cand_fail = fail_q | qclamped;

        unique case (state_q)
            ST_COLLECT: begin
                accept  = sample_valid;
                cnt_acc = cnt_q + {2'b00, accept};
                if (accept) begin
                    x_d[cnt_q[1:0]] = sample;
                    last_smp        = sample;
                end
                if (cnt_acc == 3'(GROUP) || (flush && cnt_acc != 3'd0)) begin
                    // A flushed partial group repeats its last sample into the empty slots
                    for (int i = 0; i < GROUP; i++) begin
                        if (3'(i) >= cnt_acc) x_d[i] = last_smp;
                    end
                    state_d = ST_TRY;
                    cnt_d   = 3'd0;
                    shift_d = 3'd0;
                    idx_d   = 2'd0;
                    pw_d    = p_q;
                    fail_d  = 1'b0;
                end else begin
                    cnt_d = cnt_acc;
                end
            end

            ST_TRY: begin
                qc_d[idx_q] = qqc;
                pw_d        = qr;
                fail_d      = cand_fail;
                if (idx_q == 2'(GROUP - 1)) begin
                    if (!cand_fail || shift_q == 3'(MAX_SHIFT)) begin
                        word_d  = pack_word({1'b0, shift_q}, qc_q[0], qc_q[1], qc_q[2], qqc);
                        pred_d  = qr;
                        state_d = ST_EMIT;
                    end else begin
                        shift_d = shift_q + 3'd1;
                        idx_d   = 2'd0;
                        pw_d    = p_q;
                        fail_d  = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end

            ST_EMIT: begin
                if (word_ready) begin
                    p_d     = pred_q;
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_COLLECT;
                end
            end

            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= 3'd0;
            for (int i = 0; i < GROUP; i++) begin
                x_q[i]  <= 8'sd0;
                qc_q[i] <= 4'sd0;
            end
            p_q     <= 8'sd0;
            pw_q    <= 8'sd0;
            pred_q  <= 8'sd0;
            shift_q <= 3'd0;
            idx_q   <= 2'd0;
            fail_q  <= 1'b0;
            word_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            qc_q    <= qc_d;
            p_q     <= p_d;
            pw_q    <= pw_d;
            pred_q  <= pred_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_sample_encoder.sv
// Directed bench for sample_encoder: a reference model pushes expected words and
// addresses into a scoreboard queue that is popped as the encoder presents them.
module tb_sample_encoder;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] sample = 8'sd0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic              flush = 1'b0;
    logic [19:0]       word;
    logic              word_valid;
    logic              word_ready = 1'b0;
    logic [13:0]       word_addr;

    sample_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .flush        (flush),
        .word         (word),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_addr    (word_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] w;
        logic [13:0] a;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mp    = 0;
    int   maddr = 0;
    int   gx [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder over gx[] starting from model predictor mp
    task automatic push_expected();
        int  pw, e, q, qc, r, s_sel, p_new;
        int  qv [4];
        bit  ok, done;
        exp_t ent;
        done = 0; s_sel = 4; p_new = mp;
        for (int s = 0; s <= 4; s++) begin
            if (!done) begin
                pw = mp; ok = 1;
                for (int i = 0; i < 4; i++) begin
                    e = gx[i] - pw;
                    q = e >>> s;
                    if (q > 7) begin qc = 7; ok = 0; end
                    else if (q < -8) begin qc = -8; ok = 0; end
                    else qc = q;
                    r = pw + qc * (1 << s);
                    if (r > 127) r = 127;
                    if (r < -128) r = -128;
                    qv[i] = qc;
                    pw = r;
                end
                if (ok || s == 4) begin
                    done = 1; s_sel = s; p_new = pw;
                end
            end
        end
        ent.w = {4'(s_sel), 4'(qv[0]), 4'(qv[1]), 4'(qv[2]), 4'(qv[3])};
        ent.a = 14'(maddr);
        sb.push_back(ent);
        mp    = p_new;
        maddr = (maddr + 1) % 16384;
    endtask

    task automatic send_sample(input int v, input bit fl);
        int n;
        sample = 8'(v); sample_valid = 1'b1; flush = fl; n = 0;
        while (!sample_ready && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) check("sample_accept_timeout", {31'd0, sample_ready}, 32'd1);
        @(negedge clk);
        sample_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic send_group(input int a, input int b, input int c, input int d, input bit push);
        gx[0] = a; gx[1] = b; gx[2] = c; gx[3] = d;
        if (push) push_expected();
        send_sample(a, 0); send_sample(b, 0); send_sample(c, 0); send_sample(d, 0);
    endtask

    task automatic get_word(input string tag, input int hold);
        int   n;
        exp_t ent;
        bit   held_ok;
        n = 0;
        while (!word_valid && n < 60) begin
            @(negedge clk); n++;
        end
        check({tag, "_valid"}, {31'd0, word_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            ent = sb.pop_front();
            check({tag, "_word"}, {12'd0, word}, {12'd0, ent.w});
            check({tag, "_addr"}, {18'd0, word_addr}, {18'd0, ent.a});
            if (hold > 0) begin
                held_ok = 1;
                word_ready = 1'b0;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    if (!(word_valid === 1'b1 && word === ent.w && word_addr === ent.a &&
                          sample_ready === 1'b0)) held_ok = 0;
                end
                check({tag, "_held"}, {31'd0, held_ok}, 32'd1);
            end
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check({tag, "_released"}, {30'd0, word_valid, sample_ready}, 32'b01);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        mp = 0; maddr = 0;
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit all_ready;

        do_reset();
        check("rst_word_valid", {31'd0, word_valid}, 32'd0);
        check("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
        check("rst_word", {12'd0, word}, 32'd0);
        check("rst_addr", {18'd0, word_addr}, 32'd0);

        send_group(0, 0, 0, 0, 1);      get_word("zeros", 0);
        send_group(1, 2, 3, 4, 1);      get_word("ramp1", 0);
        send_group(5, 6, 7, 8, 1);      get_word("ramp2", 0);

        do_reset();
        send_group(100, 100, 100, 100, 1); get_word("const100", 0);
        // p should now be 96: a group of 96s needs no correction
        send_group(96, 96, 96, 96, 1);     get_word("after100", 0);

        do_reset();
        send_group(127, -128, 127, -128, 1); get_word("alt_clamp", 0);
        send_group(-40, -41, -39, -40, 1);   get_word("after_alt", 0);

        // Backpressure: a sample waits through EMIT and opens the next, flushed, group
        do_reset();
        send_group(1, 2, 3, 4, 1);
        gx[0] = 3; gx[1] = 5; gx[2] = 5; gx[3] = 5;
        push_expected();
        sample = 8'sd3; sample_valid = 1'b1;
        get_word("bp", 10);
        send_sample(3, 0);
        send_sample(5, 0);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        get_word("bp_flush", 0);

        // Flush with nothing held must not start a group
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        all_ready = 1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (!(sample_ready === 1'b1 && word_valid === 1'b0)) all_ready = 0;
        end
        check("flush_k0_ignored", {31'd0, all_ready}, 32'd1);

        // Sample and flush together: sample lands first, then padding
        gx[0] = 10; gx[1] = 20; gx[2] = 20; gx[3] = 20;
        push_expected();
        send_sample(10, 0);
        send_sample(20, 1);
        get_word("smp_flush", 0);

        // Flush with the fourth sample is a plain full group
        gx[0] = -5; gx[1] = 30; gx[2] = -70; gx[3] = 12;
        push_expected();
        send_sample(-5, 0); send_sample(30, 0); send_sample(-70, 0); send_sample(12, 1);
        get_word("flush_on_4th", 0);

        for (int g = 0; g < 4; g++) begin
            send_group($signed(8'($urandom)), $signed(8'($urandom)),
                       $signed(8'($urandom)), $signed(8'($urandom)), 1);
            get_word("rand", g);
        end

        // Reset while searching: group discarded, outputs cleared without a clock edge
        send_group(50, -50, 60, -60, 0);
        check("in_try", {30'd0, sample_ready, word_valid}, 32'b00);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", {31'd0, sample_ready}, 32'd1);
        check("async_rst_valid", {31'd0, word_valid}, 32'd0);
        check("async_rst_addr", {18'd0, word_addr}, 32'd0);
        check("async_rst_word", {12'd0, word}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mp = 0; maddr = 0;
        sb.delete();
        @(negedge clk);
        send_group(1, 2, 3, 4, 1);
        get_word("post_rst", 0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
